// File: rtl/program_loader_pkg.sv
// Shared constants for the NBBPU program loader: frame marker, FSM encoding,
// and the instruction layout the opcode decoder also depends on.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int INSTR_WIDTH = 16;
  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 12;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_HI  = 4'd1;
  localparam logic [3:0] ST_LEN_LO  = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_WRITE   = 4'd5;
  localparam logic [3:0] ST_CHECK   = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERROR   = 4'd8;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader for NBBPU instruction memory. Assembles 16-bit
// words high byte first, writes them sequentially, and releases the core on a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   cpu_halt,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    words_loaded
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  logic [3:0]  state;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [7:0]  checksum;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] wl_next;
  logic        xfer;
  logic        len_bad;
  logic        is_sync;

  assign rx_ready = (state != ST_WRITE);
  assign xfer     = rx_valid & rx_ready;
  assign is_sync  = (rx_byte == SYNC_BYTE);
  assign len_in   = {len_hi, rx_byte};
  assign len_bad  = (len_in == 16'd0) || (32'(len_in) > DEPTH);
  assign wl_next  = 16'(words_loaded) + 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_hi       <= '0;
      data_hi      <= '0;
      checksum     <= '0;
      len          <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      imem_we      <= 1'b0;
      cpu_halt     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Strobe is armed by the low data byte and lives only for the WRITE cycle.
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (xfer && is_sync) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            cpu_halt     <= 1'b1;
            state        <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi <= rx_byte;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len <= len_in;
            if (len_bad) begin
              error <= 1'b1;
              state <= ST_ERROR;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (xfer) begin
            data_hi  <= rx_byte;
            checksum <= checksum ^ rx_byte;
            state    <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (xfer) begin
            imem_wdata <= {data_hi, rx_byte};
            imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
            imem_we    <= 1'b1;
            checksum   <= checksum ^ rx_byte;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          state        <= (wl_next == len) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: begin
          if (xfer) begin
            if (rx_byte == checksum) begin
              done     <= 1'b1;
              cpu_halt <= 1'b0;
              state    <= ST_DONE;
            end else begin
              error <= 1'b1;
              state <= ST_ERROR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames checked against a frame-level model of expected writes and status.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        imem_we;
  logic        cpu_halt;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int n_cmp = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int stall_cnt = 0;
  int we_ready_bad = 0;

  logic [23:0] wr_q[$];
  logic [23:0] exp_wr[$];
  logic [15:0] wq[$];
  logic [7:0]  frame[$];
  bit          exp_done, exp_err;
  int          exp_words;

  program_loader dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_we(imem_we), .cpu_halt(cpu_halt), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      we_cnt++;
    end
    if (rx_valid && !rx_ready) stall_cnt++;
  end

  // The strobe must coincide exactly with the one cycle the link is refused.
  always @(negedge clock)
    if (reset && (imem_we !== !rx_ready)) we_ready_bad++;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    rx_byte = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (rx_ready) ok = 1;
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte timeout: rx_ready stuck at %b, required 1", rx_ready);
    end
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) send_byte(frame[i], gaps);
    rx_valid = 1'b0;
    @(negedge clock);
  endtask

  // Frame-level model: words come from wq (or random), word k expected at address k,
  // done iff the trailing byte equals the XOR of all data bytes.
  task automatic make_frame(input int len, input bit use_wq, input int chk_force);
    logic [15:0] w;
    logic [7:0]  x;
    logic [15:0] l16;
    l16 = 16'(len);
    frame.delete(); exp_wr.delete(); wr_q.delete();
    frame.push_back(SYNC);
    frame.push_back(l16[15:8]);
    frame.push_back(l16[7:0]);
    if (len == 0 || len > 256) begin
      exp_err = 1; exp_done = 0; exp_words = 0;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < len; k++) begin
      w = use_wq ? wq[k] : 16'($urandom);
      frame.push_back(w[15:8]);
      frame.push_back(w[7:0]);
      x = x ^ w[15:8] ^ w[7:0];
      exp_wr.push_back({8'(k), w});
    end
    if (chk_force >= 0) frame.push_back(8'(chk_force));
    else frame.push_back(x);
    exp_done = (frame[frame.size()-1] == x);
    exp_err = !exp_done;
    exp_words = len;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if ({cpu_halt, done, error, rx_ready, imem_we} !== 5'b10010) begin n_fail++;
      $display("FAIL reset_flags: halt/done/err/rdy/we=%b required 10010", {cpu_halt, done, error, rx_ready, imem_we}); end
    n_cmp++; if ({words_loaded, imem_addr, imem_wdata} !== 33'd0) begin n_fail++;
      $display("FAIL reset_regs: wl=%0d addr=%0h wdata=%0h required all zero", words_loaded, imem_addr, imem_wdata); end
    reset = 1'b1;
    @(negedge clock);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (we_cnt !== 0 || cpu_halt !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL stray_bytes: we_cnt=%0d halt=%b done=%b required 0 1 0", we_cnt, cpu_halt, done); end
  endtask

  task automatic test_good_frame();
    wq = '{16'h1234, 16'hD56E};
    make_frame(2, 1, -1);
    send_frame(0);
    n_cmp++; if (wr_q.size() !== 2) begin n_fail++;
      $display("FAIL good_wcount: got %0d required 2", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 24'h00_1234) begin n_fail++;
        $display("FAIL good_w0: got %h required 001234", wr_q[0]); end
      n_cmp++; if (wr_q[1] !== 24'h01_D56E) begin n_fail++;
        $display("FAIL good_w1: got %h required 01d56e", wr_q[1]); end
    end
    n_cmp++; if ({done, error, cpu_halt} !== 3'b100 || words_loaded !== 9'd2) begin n_fail++;
      $display("FAIL good_status: d/e/h=%b wl=%0d required 100 2", {done, error, cpu_halt}, words_loaded); end
  endtask

  task automatic test_bad_chk();
    wq = '{16'h1234, 16'hD56E};
    make_frame(2, 1, 0);
    send_frame(0);
    n_cmp++; if (wr_q.size() !== 2) begin n_fail++;
      $display("FAIL badchk_wcount: got %0d required 2", wr_q.size()); end
    n_cmp++; if ({done, error, cpu_halt} !== 3'b011) begin n_fail++;
      $display("FAIL badchk_status: d/e/h=%b required 011", {done, error, cpu_halt}); end
    send_byte(SYNC, 0);
    rx_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if ({done, error, cpu_halt} !== 3'b001 || words_loaded !== 9'd0) begin n_fail++;
      $display("FAIL sync_clears: d/e/h=%b wl=%0d required 001 0", {done, error, cpu_halt}, words_loaded); end
    do_reset();
  endtask

  task automatic test_bad_len();
    int we0;
    int lens[2] = '{0, 257};
    foreach (lens[i]) begin
      we0 = we_cnt;
      make_frame(lens[i], 0, -1);
      send_frame(0);
      n_cmp++; if (error !== 1'b1 || done !== 1'b0 || cpu_halt !== 1'b1 || we_cnt !== we0) begin n_fail++;
        $display("FAIL bad_len %0d: err=%b done=%b halt=%b writes=%0d required 1 0 1 0",
                 lens[i], error, done, cpu_halt, we_cnt - we0); end
    end
  endtask

  task automatic test_back_to_back();
    int s0 = stall_cnt;
    make_frame(2, 0, -1);
    send_frame(0);
    n_cmp++; if (stall_cnt - s0 !== 2) begin n_fail++;
      $display("FAIL b2b_stalls: got %0d required 2", stall_cnt - s0); end
    n_cmp++; if (wr_q.size() !== 2 || wr_q[0] !== exp_wr[0] || wr_q[1] !== exp_wr[1]) begin n_fail++;
      $display("FAIL b2b_writes: n=%0d required 2 with %h %h", wr_q.size(), exp_wr[0], exp_wr[1]); end
    n_cmp++; if (done !== 1'b1 || words_loaded !== 9'd2) begin n_fail++;
      $display("FAIL b2b_status: done=%b wl=%0d required 1 2", done, words_loaded); end
  endtask

  task automatic test_reset_mid();
    wr_q.delete();
    send_byte(SYNC, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    do_reset();
    repeat (2) @(negedge clock);
    n_cmp++; if (wr_q.size() !== 0 || cpu_halt !== 1'b1) begin n_fail++;
      $display("FAIL abort_write: writes=%0d halt=%b required 0 1", wr_q.size(), cpu_halt); end
    make_frame(3, 0, -1);
    send_frame(0);
    n_cmp++; if (wr_q !== exp_wr || done !== 1'b1 || words_loaded !== 9'd3) begin n_fail++;
      $display("FAIL after_abort: writes=%0d done=%b wl=%0d required 3 1 3", wr_q.size(), done, words_loaded); end
  endtask

  task automatic test_full();
    make_frame(256, 0, -1);
    send_frame(0);
    n_cmp++; if (wr_q.size() !== 256) begin n_fail++;
      $display("FAIL full_wcount: got %0d required 256", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[255] !== exp_wr[255] || wr_q[255][23:16] !== 8'hFF) begin n_fail++;
        $display("FAIL full_last: got %h required %h", wr_q[255], exp_wr[255]); end
      n_cmp++; if (wr_q !== exp_wr) begin n_fail++;
        $display("FAIL full_contents: write sequence differs from model"); end
    end
    n_cmp++; if (done !== 1'b1 || words_loaded !== 9'd256) begin n_fail++;
      $display("FAIL full_status: done=%b wl=%0d required 1 256", done, words_loaded); end
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = 257 + $urandom_range(0, 300);
        default: len = $urandom_range(1, 8);
      endcase
      make_frame(len, 0, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : -1);
      // Stray non-SYNC bytes while parked must be swallowed.
      send_byte(8'h5A, 1);
      wr_q.delete();
      send_frame(1);
      n_cmp++; if (wr_q !== exp_wr) begin n_fail++;
        $display("FAIL rand%0d_writes: n=%0d required %0d (len %0d)", f, wr_q.size(), exp_wr.size(), len); end
      n_cmp++; if (done !== exp_done || error !== exp_err || cpu_halt !== !exp_done
                   || words_loaded !== 9'(exp_words)) begin n_fail++;
        $display("FAIL rand%0d_status: d/e/h=%b%b%b wl=%0d required %b%b%b %0d", f, done, error, cpu_halt,
                 words_loaded, exp_done, exp_err, !exp_done, exp_words); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_back_to_back();
    test_reset_mid();
    test_full();
    test_random();
    n_cmp++; if (we_ready_bad !== 0) begin n_fail++;
      $display("FAIL we_vs_ready: %0d cycles with imem_we != !rx_ready, required 0", we_ready_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
